shift_add_mult: RTL and testbench
=================================

Name: shift_add_mult

Overview:
- Sequential unsigned shift-and-add multiplier for the top-level arithmetic datapath.
- Consumes one W-bit operand pair per transaction and iterates one multiplier bit per clock.
- Uses the half/full-adder carry chain as its per-cycle accumulate step.
- Produces a 2W-bit product with a start/busy/done handshake toward the controller.

Parameters:
- WIDTH, 8, operand width W in bits; product is 2*WIDTH bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when the block is in IDLE or DONE.
- a_in  input  WIDTH  multiplicand, captured on the accepting edge.
- b_in  input  WIDTH  multiplier, captured on the accepting edge.
- busy  output  1  high while the block is iterating (CALC state).
- done  output  1  one-cycle pulse; product is valid.
- product  output  2*WIDTH  result register; holds its value until the next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, product=0.
  - Internal acc, multiplicand reg, multiplier shift reg and bit counter all clear to 0.
- States: IDLE, CALC, DONE. Binary encoding, 2 bits.
- IDLE:
  - start=1 at an edge is an accept: a_reg<=a_in; acc<={WIDTH zeros, b_in}; cnt<=0; next state CALC.
  - start=0: stay in IDLE.
- CALC (busy=1), one step per edge:
  - sum = acc[2W-1:W] + (acc[0] ? a_reg : 0), computed as a (W+1)-bit sum including carry-out.
  - acc <= {sum, acc[W-1:1]}, a right shift that keeps the carry.
  - cnt <= cnt+1.
  - When cnt==WIDTH-1 on this edge, the step is the last one: product<=the new acc value; next state DONE.
  - Exactly WIDTH CALC cycles per transaction.
- DONE: done=1 and busy=0 for exactly one cycle.
  - start=1 in DONE is accepted as in IDLE (back-to-back; next state CALC; done still pulses this cycle).
  - start=0: next state IDLE.
- Latency: an accept at edge k gives busy high for cycles k+1..k+WIDTH; done high during cycle k+WIDTH+1. Throughput is one product per WIDTH+1 cycles.
- start while in CALC is ignored. a_in/b_in are don't-care outside the accepting edge. The operand registers are unaffected by input changes during CALC.
- product changes only at the final CALC edge. It is stable during the following IDLE/CALC cycles until the next completion.
- Arithmetic is unsigned. Result is exact, with no overflow: (2^W-1)^2 < 2^(2W).
- Reset asserted mid-CALC aborts the transaction:
  - Outputs return to reset values immediately, without waiting for a clock.
  - No done is produced.
  - After rst_n deasserts, the first edge with start=1 begins a fresh transaction.
- busy and done are never high simultaneously. done never asserts without a preceding accept.

Test Plan:
- Basic: WIDTH=8, reset, then start with a=13, b=11 -> busy high 8 cycles; done pulses 9 cycles after the accept edge; product=143 (0x008F).
- Extremes: a=255, b=255 -> product=65025 (0xFE01). Then a=0, b=200 -> product=0. Then a=1, b=128 -> product=128. Check carry-out retention on every step.
- Back-to-back: hold start=1 with a=7, b=6, then a=9, b=9 presented in the DONE cycle -> done pulses for 42; busy reasserts the next cycle; second done pulses 9 cycles later with product=81; no IDLE gap.
- Ignored start: accept a=3, b=5, then pulse start with a=100, b=100 during CALC cycle 4 -> product=15; done timing unchanged; exactly one done.
- Reset mid-op: accept a=200, b=3, then drive rst_n low asynchronously (between edges) in CALC cycle 5 -> busy=0, done=0, product=0 immediately. Release, accept a=2, b=2 -> product=4 after the normal 9-cycle latency.
- Hold check: after product=143 completes, idle 20 cycles with a_in/b_in toggling -> product stays 143, done stays 0.

Source files
------------

// File: rtl/shift_add_mult_if.sv
// Handshake and operand/result bundle between the controller and shift_add_mult.
// The controller drives start/a_in/b_in; the multiplier returns busy/done/product.
interface shift_add_mult_if #(
  parameter int unsigned WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, a_in, b_in,
    input  busy, done, product
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, product
  );
endinterface

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier: one multiplier bit per clock,
// WIDTH CALC cycles per product, start/busy/done handshake.
module shift_add_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  shift_add_mult_if.slave bus
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [PW-1:0]    acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [PW-1:0]    product_q;

  logic [WIDTH-1:0] addend_c;
  logic [WIDTH:0]   sum_c;
  logic [PW-1:0]    acc_next_c;
  logic             last_step_c;

  // Accumulate step: upper half plus gated multiplicand, carry kept in the shift.
  always_comb begin
    addend_c    = acc_q[0] ? a_q : '0;
    sum_c       = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, addend_c};
    acc_next_c  = {sum_c, acc_q[WIDTH-1:1]};
    last_step_c = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // DONE accepts a new request exactly like IDLE, giving back-to-back operation.
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            a_q     <= bus.a_in;
            acc_q   <= {{WIDTH{1'b0}}, bus.b_in};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_CALC;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_CALC: begin
          acc_q <= acc_next_c;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_step_c) begin
            product_q <= acc_next_c;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed scoreboard bench for shift_add_mult (WIDTH=8): latency, back-to-back,
// ignored start, asynchronous abort and product hold behaviour.
module tb_shift_add_mult;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 2 * W;

  logic clk;
  logic rst_n;

  shift_add_mult_if #(.WIDTH(W)) bus ();

  shift_add_mult #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  logic [PW-1:0] sb[$];
  logic [PW-1:0] prod_hold;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a request at a negedge; returns at the negedge after the accepting edge.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    sb.push_back(PW'(a) * PW'(b));
    @(negedge clk);
    bus.start = 1'b0;
    bus.a_in  = W'($urandom);
    bus.b_in  = W'($urandom);
  endtask

  // Walk the WIDTH CALC cycles, then check the done cycle against the scoreboard.
  task automatic expect_calc(input int poke_at);
    logic [PW-1:0] exp_p;
    for (int i = 0; i < int'(W); i++) begin
      check("busy_in_calc", 64'(bus.busy), 64'd1);
      check("done_in_calc", 64'(bus.done), 64'd0);
      check("product_hold_calc", 64'(bus.product), 64'(prod_hold));
      if (i == poke_at) begin
        bus.start = 1'b1;
        bus.a_in  = W'(100);
        bus.b_in  = W'(100);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("done_pulse", 64'(bus.done), 64'd1);
    check("busy_in_done", 64'(bus.busy), 64'd0);
    check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      exp_p = sb.pop_front();
      check("product", 64'(bus.product), 64'(exp_p));
      prod_hold = exp_p;
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_product"}, 64'(bus.product), 64'(prod_hold));
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    prod_hold = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_product", 64'(bus.product), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic 13*11, then hold for 20 cycles with toggling operands.
    accept(W'(13), W'(11));
    expect_calc(-1);
    for (int i = 0; i < 20; i++) begin
      bus.a_in = W'($urandom);
      bus.b_in = W'($urandom);
      idle_check("hold");
    end
    check("hold_value_143", 64'(bus.product), 64'h008F);

    // Extremes.
    accept(W'(255), W'(255));
    expect_calc(-1);
    idle_check("after_ff");
    accept(W'(0), W'(200));
    expect_calc(-1);
    idle_check("after_zero");
    accept(W'(1), W'(128));
    expect_calc(-1);
    idle_check("after_msb");

    // Back-to-back: second request presented in the DONE cycle.
    accept(W'(7), W'(6));
    expect_calc(-1);
    accept(W'(9), W'(9));
    expect_calc(-1);
    idle_check("after_b2b");

    // Start during CALC cycle 4 is ignored.
    accept(W'(3), W'(5));
    expect_calc(3);
    idle_check("after_ignored");
    idle_check("after_ignored2");

    // Asynchronous reset in CALC cycle 5.
    accept(W'(200), W'(3));
    for (int i = 0; i < 4; i++) begin
      check("pre_abort_busy", 64'(bus.busy), 64'd1);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_product", 64'(bus.product), 64'd0);
    void'(sb.pop_front());
    prod_hold = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_check("post_abort");
    accept(W'(2), W'(2));
    expect_calc(-1);
    idle_check("final");
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
